halfword_store: RTL and testbench

Write-side companion to the unaligned halfword read path. Accepts a 16-bit value and an arbitrary byte address and stores it into the 32-bit-word, 128-entry single-port `memory` block using read-modify-write. Byte order is big-endian: byte lane 0 is bits 31:24. A halfword at byte offset 3 straddles two words and costs two RMW passes. The block sits between switch/control logic and the memory port, in place of direct `wea` driving.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/halfword_store_if.sv | 26 ++
 rtl/halfword_merge.sv | 24 ++
 rtl/halfword_store.sv | 97 +++++++++
 tb/tb_halfword_store.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the 128 x 32-bit memory and its halfword read/write paths.
package mem_pkg;
  localparam int WORD_W    = 32;
  localparam int WORDS     = 128;
  localparam int NUM_LANES = WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    WR0  = 3'd2,
    RD1  = 3'd3,
    WR1  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Big-endian byte lanes: lane 0 is bits 31:24
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;
endpackage

// File: rtl/halfword_store_if.sv
// Request and memory-port signals of the halfword store; the store block is the slave.
interface halfword_store_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data;
  logic              busy;
  logic              done;
  logic [ADDR_W-3:0] mem_addr;
  logic [WORD_W-1:0] mem_din;
  logic              mem_we;
  logic [WORD_W-1:0] mem_dout;

  modport slave (
    input  start, addr, data, mem_dout,
    output busy, done, mem_addr, mem_din, mem_we
  );

  modport master (
    output start, addr, data, mem_dout,
    input  busy, done, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/halfword_merge.sv
// Merges a big-endian halfword into an old word; second selects the spill byte of a lane-3 store.
module halfword_merge
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [1:0]        lane,
  input  logic [15:0]       data,
  input  logic              second,
  output logic [WORD_W-1:0] merged
);
  logic [0:NUM_LANES-1][7:0] o;
  logic [0:NUM_LANES-1][7:0] m;

  assign o      = old_word;
  assign merged = m;

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    // high byte lands in lane, low byte in lane+1 (falls off the word for lane 3)
    assign m[b] = second                          ? ((b == 0) ? data[7:0] : o[b]) :
                  (lane == 2'(b))                 ? data[15:8] :
                  ({1'b0, lane} + 3'd1 == 3'(b))  ? data[7:0]  :
                                                    o[b];
  end
endmodule

// File: rtl/halfword_store.sv
// Read-modify-write halfword store into a word-wide single-port memory; lane-3 stores take two passes.
module halfword_store
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  halfword_store_if.slave  bus
);
  localparam int WA_W = ADDR_W - 2;

  state_t            state, state_nxt;
  logic [WA_W-1:0]   w;
  logic [WA_W-1:0]   w_inc;
  logic [1:0]        lane;
  logic [15:0]       data_q;
  logic              second;
  logic [WORD_W-1:0] merged;

  // wraps naturally at the top of the word space
  assign w_inc  = w + WA_W'(1);
  assign second = (state == RD1) || (state == WR1);

  halfword_merge u_merge (
    .old_word (bus.mem_dout),
    .lane     (lane),
    .data     (data_q),
    .second   (second),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w      <= '0;
      lane   <= '0;
      data_q <= '0;
    end else if (state == IDLE && bus.start) begin
      w      <= bus.addr[ADDR_W-1:2];
      lane   <= bus.addr[1:0];
      data_q <= bus.data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RD0;
      RD0:     state_nxt = WR0;
      WR0:     state_nxt = (lane == LANE3) ? RD1 : DONE;
      RD1:     state_nxt = WR1;
      WR1:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.mem_we   = 1'b0;
    case (state)
      RD0: begin
        bus.busy     = 1'b1;
        bus.mem_addr = w;
      end
      WR0: begin
        bus.busy     = 1'b1;
        bus.mem_addr = w;
        bus.mem_we   = 1'b1;
        bus.mem_din  = merged;
      end
      RD1: begin
        bus.busy     = 1'b1;
        bus.mem_addr = w_inc;
      end
      WR1: begin
        bus.busy     = 1'b1;
        bus.mem_addr = w_inc;
        bus.mem_we   = 1'b1;
        bus.mem_din  = merged;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_halfword_store.sv
// Bench for halfword_store: behavioural memory plus a byte-array reference model.
module tb_halfword_store;
  import mem_pkg::*;

  localparam int ADDR_W = 9;
  localparam int NBYTES = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  halfword_store_if #(.ADDR_W(ADDR_W)) bus ();

  halfword_store #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [WORD_W-1:0] mem [WORDS];
  logic              pl_en = 1'b0;
  logic [6:0]        pl_addr = '0;
  logic [31:0]       pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)            mem[pl_addr] <= pl_data;
    else if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  logic [7:0] rb [NBYTES];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic logic [31:0] ref_word(int k);
    return {rb[4*k], rb[4*k+1], rb[4*k+2], rb[4*k+3]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(int k, logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = 7'(k); pl_data = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
    for (int b = 0; b < 4; b++) rb[4*k+b] = v[31-8*b -: 8];
  endtask

  task automatic store(logic [ADDR_W-1:0] a, logic [15:0] d, bit pulse_busy);
    int         done_k;
    logic [5:0] we_mask;
    bit         busy_ok;
    int         lane, wi, idx;
    @(negedge clk);
    check("idle_before_start", 32'(bus.busy), 32'd0);
    bus.start = 1'b1; bus.addr = a; bus.data = d;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_k = 0; we_mask = '0; busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pulse_busy && k == 1) begin
        bus.start = 1'b1; bus.addr = 9'h010; bus.data = 16'h5A5A;
      end else bus.start = 1'b0;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.mem_we && k <= 5) we_mask[k] = 1'b1;
      if (bus.done) begin done_k = k; break; end
    end
    bus.start = 1'b0;
    idx  = int'(a);
    lane = idx % 4;
    wi   = idx / 4;
    check("done_cycle", 32'(done_k), (lane == 3) ? 32'd5 : 32'd3);
    check("we_pulses", 32'(we_mask), (lane == 3) ? 32'b010100 : 32'b000100);
    check("busy_held", 32'(busy_ok), 32'd1);
    rb[idx] = d[15:8];
    rb[(idx + 1) % NBYTES] = d[7:0];
    for (int j = -1; j <= 2; j++) begin
      int k;
      k = (wi + j + WORDS) % WORDS;
      check($sformatf("word%0d", k), mem[k], ref_word(k));
    end
  endtask

  initial begin
    bit saw_done;
    bus.start = 1'b0; bus.addr = '0; bus.data = '0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_din", bus.mem_din, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < WORDS; k++) preload(k, $urandom());

    preload(0, 32'h11223344);
    store(9'h000, 16'hABCD, 1'b0);
    check("tp_aligned_w0", mem[0], 32'hABCD3344);

    preload(1, 32'h11223344);
    store(9'h005, 16'hABCD, 1'b0);
    check("tp_lane1_w1", mem[1], 32'h11ABCD44);

    preload(1, 32'h11223344);
    preload(2, 32'h55667788);
    store(9'h007, 16'hABCD, 1'b0);
    check("tp_strad_w1", mem[1], 32'h112233AB);
    check("tp_strad_w2", mem[2], 32'hCD667788);

    preload(127, 32'h0);
    preload(0, 32'h0);
    store(9'h1FF, 16'hBEEF, 1'b0);
    check("tp_wrap_w127", mem[127], 32'h000000BE);
    check("tp_wrap_w0", mem[0], 32'hEF000000);

    preload(4, 32'hDEADBEEF);
    store(9'h000, 16'h1234, 1'b1);
    check("ignored_start_w4", mem[4], 32'hDEADBEEF);
    store(9'h011, 16'h7777, 1'b0);

    repeat (12) store(9'($urandom_range(NBYTES - 1)), 16'($urandom()), 1'b0);

    // lane-3 store interrupted by reset during the second read
    preload(10, 32'h01020304);
    preload(11, 32'h05060708);
    @(negedge clk);
    bus.start = 1'b1; bus.addr = 9'h02B; bus.data = 16'hC3A5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rd1_addr", 32'(bus.mem_addr), 32'd11);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_we", 32'(bus.mem_we), 32'd0);
    saw_done = bus.done;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    check("rst_mid_no_done", 32'(saw_done), 32'd0);
    rb[43] = 8'hC3;
    check("rst_mid_w10", mem[10], ref_word(10));
    check("rst_mid_w11", mem[11], 32'h05060708);

    store(9'h02B, 16'h9966, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
